task_pc_seq: RTL and testbench

//   Next-generation program counter for the task micro-sequencer. Decodes the
//   per-cycle task bitmask into the next PC using:
//   - a parametrised jump table;
//   - an indirect jump;
//   - a call/return stack;
//   - an internal repeat counter, so instruction hold time is no longer driven externally.

---
 rtl/task_pc_seq.sv | 194 +++++++++++++++++++
 tb/tb_task_pc_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/task_pc_seq.sv
// task_pc_seq: next-PC sequencer for the task micro-sequencer.
// Priority per enabled cycle: repeat hold, return, call, jump table, indirect, increment.
module task_pc_seq #(
  parameter int unsigned                     PC_W        = 6,
  parameter int unsigned                     TASKS_W     = 16,
  parameter int unsigned                     N_JP        = 8,
  parameter logic [N_JP*(TASKS_W+PC_W)-1:0]  JP_TABLE    = '0,
  parameter logic [TASKS_W-1:0]              TASK_JPI    = '0,
  parameter logic [TASKS_W-1:0]              TASK_CALL   = '0,
  parameter logic [TASKS_W-1:0]              TASK_RET    = '0,
  parameter logic [TASKS_W-1:0]              TASK_RPT    = '0,
  parameter int unsigned                     STACK_DEPTH = 4,
  parameter int unsigned                     RPT_W       = 8,
  localparam int unsigned                    SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [TASKS_W-1:0] tasks,
  input  logic [PC_W-1:0]    jp_addr,
  input  logic [RPT_W-1:0]   rpt_len,
  input  logic               err_clr,
  output logic [PC_W-1:0]    pc_out,
  output logic [SP_W-1:0]    sp_out,
  output logic               rpt_busy,
  output logic               err_ovf,
  output logic               err_unf
);

  localparam int unsigned ENT_W = TASKS_W + PC_W;
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic {
    RPT_IDLE,
    RPT_HOLD
  } rpt_state_t;

  rpt_state_t       r_state;
  rpt_state_t       w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [PC_W-1:0]  w_pc_inc;
  logic [SP_W-1:0]  r_sp;
  logic [SP_W-1:0]  w_sp_nxt;
  logic [RPT_W-1:0] r_cnt;
  logic [RPT_W-1:0] w_cnt_nxt;
  logic             r_err_ovf;
  logic             r_err_unf;
  logic             w_set_ovf;
  logic             w_set_unf;
  logic             w_push;
  logic             w_hold;
  logic             w_jp_hit;
  logic [PC_W-1:0]  w_jp_tgt;
  logic [PC_W-1:0]  w_pop_data;
  logic [IDX_W-1:0] w_push_idx;
  logic [IDX_W-1:0] w_pop_idx;
  logic             w_hit_rpt;
  logic             w_hit_ret;
  logic             w_hit_call;
  logic             w_hit_jpi;

  logic [PC_W-1:0]  r_stack [STACK_DEPTH];

  assign w_pc_inc   = r_pc + PC_W'(1);
  assign w_hit_rpt  = (tasks & TASK_RPT)  != '0;
  assign w_hit_ret  = (tasks & TASK_RET)  != '0;
  assign w_hit_call = (tasks & TASK_CALL) != '0;
  assign w_hit_jpi  = (tasks & TASK_JPI)  != '0;
  assign w_push_idx = IDX_W'(r_sp);
  assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));
  assign w_pop_data = r_stack[w_pop_idx];

  // Jump-table match: scanning upward lets the highest-index hit win.
  always_comb begin
    w_jp_hit = 1'b0;
    w_jp_tgt = '0;
    for (int unsigned i = 0; i < N_JP; i++) begin
      if ((JP_TABLE[i*ENT_W+PC_W +: TASKS_W] & tasks) != '0) begin
        w_jp_hit = 1'b1;
        w_jp_tgt = JP_TABLE[i*ENT_W +: PC_W];
      end
    end
  end

  // Next-state decode: repeat FSM first, then prioritised PC selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_push      = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_unf   = 1'b0;
    w_hold      = 1'b0;
    if (en) begin
      if (w_hit_rpt) begin
        unique case (r_state)
          RPT_IDLE: begin
            if (rpt_len != '0) begin
              w_state_nxt = RPT_HOLD;
              w_cnt_nxt   = rpt_len;
              w_hold      = 1'b1;
            end
          end
          RPT_HOLD: begin
            if (r_cnt > RPT_W'(1)) begin
              w_cnt_nxt = r_cnt - RPT_W'(1);
              w_hold    = 1'b1;
            end else begin
              w_state_nxt = RPT_IDLE;
              w_cnt_nxt   = '0;
            end
          end
          default: begin
            w_state_nxt = RPT_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end else begin
        // Repeat task dropped mid-hold: abandon the hold and decode normally.
        w_state_nxt = RPT_IDLE;
        w_cnt_nxt   = '0;
      end

      if (!w_hold) begin
        if (w_hit_ret) begin
          if (r_sp != '0) begin
            w_pc_nxt = w_pop_data;
            w_sp_nxt = r_sp - SP_W'(1);
          end else begin
            w_set_unf = 1'b1;
            w_pc_nxt  = w_pc_inc;
          end
        end else if (w_hit_call) begin
          if (r_sp < SP_W'(STACK_DEPTH)) begin
            w_push   = 1'b1;
            w_sp_nxt = r_sp + SP_W'(1);
            w_pc_nxt = jp_addr;
          end else begin
            w_set_ovf = 1'b1;
            w_pc_nxt  = w_pc_inc;
          end
        end else if (w_jp_hit) begin
          w_pc_nxt = w_jp_tgt;
        end else if (w_hit_jpi) begin
          w_pc_nxt = jp_addr;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RPT_IDLE;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_sp    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pc    <= w_pc_nxt;
      r_sp    <= w_sp_nxt;
    end
  end

  // Sticky error flags: a new error beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      r_err_ovf <= w_set_ovf | (r_err_ovf & ~err_clr);
      r_err_unf <= w_set_unf | (r_err_unf & ~err_clr);
    end
  end

  // Return-address storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign pc_out   = r_pc;
  assign sp_out   = r_sp;
  assign rpt_busy = (r_state == RPT_HOLD);
  assign err_ovf  = r_err_ovf;
  assign err_unf  = r_err_unf;

endmodule

// File: tb/tb_task_pc_seq.sv
// tb_task_pc_seq: directed plus randomized checks of task_pc_seq against a queue-based model.
module tb_task_pc_seq;

  localparam logic [8*22-1:0] TB_JP = {{6{22'h0}}, 16'h0030, 6'd40, 16'h0010, 6'd20};

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [15:0] tasks;
  logic [5:0]  jp_addr;
  logic [7:0]  rpt_len;
  logic        err_clr;
  logic [5:0]  pc_out;
  logic [2:0]  sp_out;
  logic        rpt_busy;
  logic        err_ovf;
  logic        err_unf;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int m_pc;
  int m_stk[$];
  int m_cnt;
  bit m_busy;
  bit m_ovf;
  bit m_unf;
  int tbl_mask[8];
  int tbl_tgt[8];

  task_pc_seq #(
    .PC_W(6),
    .TASKS_W(16),
    .N_JP(8),
    .JP_TABLE(TB_JP),
    .TASK_JPI(16'h0008),
    .TASK_CALL(16'h0001),
    .TASK_RET(16'h0002),
    .TASK_RPT(16'h0004),
    .STACK_DEPTH(4),
    .RPT_W(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .tasks(tasks),
    .jp_addr(jp_addr),
    .rpt_len(rpt_len),
    .err_clr(err_clr),
    .pc_out(pc_out),
    .sp_out(sp_out),
    .rpt_busy(rpt_busy),
    .err_ovf(err_ovf),
    .err_unf(err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},   32'(pc_out),   32'(m_pc));
    chk({tag, ".sp"},   32'(sp_out),   32'(m_stk.size()));
    chk({tag, ".busy"}, 32'(rpt_busy), 32'(m_busy));
    chk({tag, ".ovf"},  32'(err_ovf),  32'(m_ovf));
    chk({tag, ".unf"},  32'(err_unf),  32'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_cnt = 0;
    m_busy = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  // One clock of sequencer behaviour expressed directly from the decode rules.
  task automatic model_step(input int t, input int j, input int r, input bit e, input bit c);
    bit hold = 0;
    bit new_ovf = 0;
    bit new_unf = 0;
    int tgt = -1;
    if (e) begin
      if ((t & 4) != 0) begin
        if (!m_busy) begin
          if (r > 0) begin m_cnt = r; m_busy = 1; hold = 1; end
        end else if (m_cnt > 1) begin
          m_cnt = m_cnt - 1; hold = 1;
        end else begin
          m_busy = 0; m_cnt = 0;
        end
      end else begin
        m_busy = 0; m_cnt = 0;
      end
      if (!hold) begin
        for (int i = 0; i < 8; i++)
          if ((tbl_mask[i] & t) != 0) tgt = tbl_tgt[i];
        if ((t & 2) != 0) begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin new_unf = 1; m_pc = (m_pc + 1) % 64; end
        end else if ((t & 1) != 0) begin
          if (m_stk.size() < 4) begin m_stk.push_back((m_pc + 1) % 64); m_pc = j; end
          else begin new_ovf = 1; m_pc = (m_pc + 1) % 64; end
        end else if (tgt >= 0) begin
          m_pc = tgt;
        end else if ((t & 8) != 0) begin
          m_pc = j;
        end else begin
          m_pc = (m_pc + 1) % 64;
        end
      end
    end
    m_ovf = new_ovf | (m_ovf & !c);
    m_unf = new_unf | (m_unf & !c);
  endtask

  task automatic cyc(input string tag, input int t, input int j, input int r,
                     input bit e, input bit c);
    tasks   = 16'(t);
    jp_addr = 6'(j);
    rpt_len = 8'(r);
    en      = e;
    err_clr = c;
    @(posedge clk);
    model_step(t, j, r, e, c);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin tbl_mask[i] = 0; tbl_tgt[i] = 0; end
    tbl_mask[0] = 'h0010; tbl_tgt[0] = 20;
    tbl_mask[1] = 'h0030; tbl_tgt[1] = 40;

    reset_n = 1'b0;
    en = 1'b0; tasks = '0; jp_addr = '0; rpt_len = '0; err_clr = 1'b0;
    model_reset();
    #12;
    check_all("reset0");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Free-running increment across the wrap point
    for (int k = 0; k < 70; k++) cyc("wrap", 0, 0, 0, 1, 0);

    // Jump table and indirect jump
    do_reset();
    for (int k = 0; k < 5; k++) cyc("adv", 0, 0, 0, 1, 0);
    cyc("tbl10", 'h0010, 0, 0, 1, 0);
    cyc("tbl20", 'h0020, 0, 0, 1, 0);
    cyc("tbl30", 'h0030, 0, 0, 1, 0);
    cyc("jpi", 'h0008, 9, 0, 1, 0);
    cyc("tbl_over_jpi", 'h0018, 3, 0, 1, 0);

    // Repeat hold, then zero-length repeat
    do_reset();
    for (int k = 0; k < 3; k++) cyc("adv", 0, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) cyc("rpt3", 'h0004, 0, 3, 1, 0);
    cyc("rpt0", 'h0004, 0, 0, 1, 0);
    cyc("rpt_drop_a", 'h0004, 0, 5, 1, 0);
    cyc("rpt_drop_b", 'h0000, 0, 5, 1, 0);

    // Call stack fill, overflow, drain, underflow, clear
    do_reset();
    cyc("adv", 0, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc("call", 'h0001, 10 * k, 0, 1, 0);
      if (k < 4) cyc("adv", 0, 0, 0, 1, 0);
    end
    cyc("call_ovf", 'h0001, 50, 0, 1, 0);
    for (int k = 0; k < 4; k++) cyc("ret", 'h0002, 0, 0, 1, 0);
    cyc("ret_unf", 'h0002, 0, 0, 1, 0);
    cyc("clr_vs_new", 'h0002, 0, 0, 1, 1);
    cyc("clr", 0, 0, 0, 1, 1);

    // Return beats call; freeze during a repeat
    cyc("call1", 'h0001, 7, 0, 1, 0);
    cyc("call_ret", 'h0003, 33, 0, 1, 0);
    cyc("ret_unf2", 'h0002, 0, 0, 1, 0);
    cyc("rpt_go", 'h0004, 0, 5, 1, 0);
    cyc("rpt_go2", 'h0004, 0, 5, 1, 0);
    for (int k = 0; k < 5; k++)
      cyc("freeze", int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 2, 0, (k == 4));
    for (int k = 0; k < 5; k++) cyc("rpt_resume", 'h0004, 0, 5, 1, 0);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 600; k++) begin
      int t = 0;
      for (int b = 0; b < 6; b++)
        if ($urandom_range(0, 3) == 0) t = t | (1 << b);
      cyc("rand", t, int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset mid-repeat with two stack entries
    do_reset();
    cyc("c1", 'h0001, 12, 0, 1, 0);
    cyc("c2", 'h0001, 24, 0, 1, 0);
    cyc("r1", 'h0004, 0, 6, 1, 0);
    cyc("r2", 'h0004, 0, 6, 1, 0);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #3;
    reset_n = 1'b1;
    #1;
    cyc("post_rst", 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
